// File: rtl/imem.sv
// ----------------------------------------------------------------------------
// imem: instruction memory with a valid/ready fetch port and a side loader.
//
// A fetch request carries a byte address. It is split into a word index
// (address >> log2(DWIDTH/8)) and the byte offset within the word. Misaligned
// or out-of-range fetches return rsp_err=1 with rsp_data=0, and the memory is
// not read for them. Good fetches return the memory word as it was at the
// accept edge. Responses come out LATENCY advancing cycles after acceptance,
// in order. The whole pipeline freezes while a valid response waits on
// rsp_ready.
//
// The loader port writes one word per cycle and has priority over fetches:
// req_ready drops while ld_en is high. Responses already in flight keep
// draining while a load happens.
//
// Parameters
//   AWIDTH   request byte-address width
//   DWIDTH   instruction word width (multiple of 8)
//   WORDS    memory depth in words (power of 2)
//   LATENCY  1 or 2 cycles from accept to rsp_valid
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   fetch handshake
//   req_addr              fetch byte address
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     instruction word, misaligned/out-of-range flag
//   ld_en/ld_addr/ld_data loader write strobe, word index, data
// ----------------------------------------------------------------------------
module imem #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int WORDS   = 4096,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AWIDTH-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DWIDTH-1:0]        rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(WORDS)-1:0] ld_addr,
    input  logic [DWIDTH-1:0]        ld_data
);

    localparam int IW    = $clog2(WORDS);
    localparam int BYTES = DWIDTH / 8;
    localparam int OFFW  = (BYTES > 1) ? $clog2(BYTES) : 0;

    localparam logic [AWIDTH-1:0] OFF_MASK  = AWIDTH'((64'd1 << OFFW) - 64'd1);
    localparam logic [AWIDTH:0]   WORDS_LIM = (AWIDTH+1)'(WORDS);

    logic [AWIDTH-1:0] wordIdx;
    logic              reqErr;
    logic              advance;
    logic              accept;

    // The index is kept at full address width so the range check also sees
    // addresses whose upper bits would alias into the array.
    assign wordIdx = req_addr >> OFFW;
    assign reqErr  = ((req_addr & OFF_MASK) != '0) || ({1'b0, wordIdx} >= WORDS_LIM);

    assign advance   = !(rsp_valid && !rsp_ready);
    assign req_ready = advance && !ld_en;
    assign accept    = req_valid && req_ready;

    // Memory array with registered read and no reset, so it maps onto block
    // RAM. The read register only loads on a good accept, which can only
    // happen while advancing, so it holds its value across stalls.
    logic [DWIDTH-1:0] mem [WORDS];
    logic [DWIDTH-1:0] ramData_q;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept && !reqErr) begin
            ramData_q <= mem[wordIdx[IW-1:0]];
        end
    end

    // Stage 1 tags the RAM read with valid/err.
    logic s1Valid_q, s1Valid_d;
    logic s1Err_q,   s1Err_d;

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Err_d   = s1Err_q;
        if (advance) begin
            s1Valid_d = accept;
            s1Err_d   = accept && reqErr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Err_q   <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Err_q   <= s1Err_d;
        end
    end

    // The RAM register is never reset, so its data is gated by the
    // reset-cleared tags. This keeps the data at zero after reset, for
    // bubbles and for errored fetches.
    logic [DWIDTH-1:0] s1Data;
    assign s1Data = (s1Valid_q && !s1Err_q) ? ramData_q : '0;

    if (LATENCY == 2) begin : g_lat2
        logic              s2Valid_q, s2Valid_d;
        logic              s2Err_q,   s2Err_d;
        logic [DWIDTH-1:0] s2Data_q,  s2Data_d;

        always_comb begin
            s2Valid_d = s2Valid_q;
            s2Err_d   = s2Err_q;
            s2Data_d  = s2Data_q;
            if (advance) begin
                s2Valid_d = s1Valid_q;
                s2Err_d   = s1Err_q;
                s2Data_d  = s1Data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2Valid_q <= 1'b0;
                s2Err_q   <= 1'b0;
                s2Data_q  <= '0;
            end else begin
                s2Valid_q <= s2Valid_d;
                s2Err_q   <= s2Err_d;
                s2Data_q  <= s2Data_d;
            end
        end

        assign rsp_valid = s2Valid_q;
        assign rsp_err   = s2Err_q;
        assign rsp_data  = s2Data_q;
    end else begin : g_lat1
        assign rsp_valid = s1Valid_q;
        assign rsp_err   = s1Err_q;
        assign rsp_data  = s1Data;
    end

endmodule

// File: doc/imem.md
IMEM -- requirements
Module: imem

Interface
REQ-001 The block SHALL provide parameter AWIDTH, default 32, meaning request byte-address width.
REQ-002 The block SHALL provide parameter DWIDTH, default 32, meaning instruction word width (multiple of 8).
REQ-003 The block SHALL provide parameter WORDS, default 4096, meaning memory depth in words (power of 2).
REQ-004 The block SHALL provide parameter LATENCY, default 1, legal values 1 or 2, meaning cycles from request accept to response valid.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, as the two ports below.
REQ-006 clk  input  1  global clock, all state on rising edge.
REQ-007 rst_n  input  1  global asynchronous active-low reset.
REQ-008 req_valid  input  1  fetch request present.
REQ-009 req_ready  output  1  fetch request accepted when high with req_valid.
REQ-010 req_addr  input  AWIDTH  fetch byte address.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer takes response.
REQ-013 rsp_data  output  DWIDTH  instruction word.
REQ-014 rsp_err  output  1  misaligned or out-of-range fetch.
REQ-015 ld_en  input  1  loader write strobe.
REQ-016 ld_addr  input  log2(WORDS)  loader word index.
REQ-017 ld_data  input  DWIDTH  loader write data.

Function
REQ-018 Word index SHALL be req_addr >> log2(DWIDTH/8); offset bits are req_addr[log2(DWIDTH/8)-1:0].
REQ-019 A request SHALL be accepted when req_valid && req_ready at a rising edge.
REQ-020 Pipeline SHALL advance when rsp_valid==0 or rsp_ready==1 (advance = !(rsp_valid && !rsp_ready)).
REQ-021 req_ready SHALL equal advance && !ld_en (combinational).
REQ-022 An accepted request SHALL produce rsp_valid exactly LATENCY advancing cycles later, in order; no reordering, no drops.
REQ-023 While not advancing, all pipeline stages, rsp_valid, rsp_data, rsp_err SHALL hold stable.
REQ-024 Bubbles SHALL propagate: a cycle with no accepted request while advancing inserts an invalid stage.
REQ-025 rsp_err SHALL be 1 when offset bits != 0 or word index >= WORDS; then rsp_data SHALL be 0 and memory SHALL not be read.
REQ-026 Otherwise rsp_err SHALL be 0 and rsp_data SHALL be mem[word index] as of the accept edge.
REQ-027 ld_en high SHALL write ld_data to mem[ld_addr] at that edge, regardless of pipeline state.
REQ-028 A request accepted at least one cycle after a load write SHALL return the new data; same-cycle conflict is impossible (REQ-021).
REQ-029 In-flight responses SHALL complete during load cycles (loads block only acceptance).
REQ-030 For LATENCY=2, stage 1 SHALL register the memory read and stage 2 SHALL register data/err; sustained throughput SHALL be 1 word/cycle when rsp_ready=1.
REQ-031 Memory array SHALL be inferable as block RAM (synchronous read, no reset on array).

Reset
REQ-032 rst_n low SHALL asynchronously clear rsp_valid=0, rsp_data=0, rsp_err=0, all stage valid bits=0.
REQ-033 Reset mid-operation SHALL discard all in-flight requests; memory contents SHALL be retained.
REQ-034 req_ready SHALL be 1 during and after reset when ld_en=0.

Verification
REQ-035 LATENCY=1: load mem[3]=0x00A00093, request addr 0x0C, rsp_ready=1 -> rsp_valid next cycle, rsp_data=0x00A00093, rsp_err=0.
REQ-036 LATENCY=2: back-to-back requests 0x0,0x4,0x8 -> three consecutive responses starting 2 cycles after first accept, data in order.
REQ-037 Request 0x06 -> rsp_err=1, rsp_data=0; request WORDS*4 -> rsp_err=1.
REQ-038 Hold rsp_ready=0 for 3 cycles with response pending -> req_ready=0, rsp_* stable; release -> pipeline resumes, no loss or duplicate.
REQ-039 ld_en=1 with req_valid=1 -> req_ready=0, no accept; next cycle read of written index returns new data.
REQ-040 Assert rst_n=0 with 2 requests in flight (LATENCY=2) -> rsp_valid=0 immediately, no stale response after release; prior loaded data still readable.
